num_fmt_conv: RTL

Streaming, parametrised converter between two's-complement and sign-magnitude, with the direction selected per transaction.
- 2-stage registered pipeline with valid/ready handshake on both sides; sustains 1 word/cycle.
- Flags unrepresentable and negative-zero cases.
- Sits between the datapath (two's complement) and sign-magnitude consumers and producers (display/DAC/serial formats).

---
 rtl/num_fmt_pkg.sv | 12 +
 rtl/num_fmt_conv_core.sv | 50 +++++
 rtl/num_fmt_conv.sv | 109 ++++++++++
 3 files changed

// File: rtl/num_fmt_pkg.sv
// Shared constants for the two's-complement / sign-magnitude converter.
package num_fmt_pkg;

    localparam logic MODE_TC2SM = 1'b0;
    localparam logic MODE_SM2TC = 1'b1;

    // Bit pattern 100..0 for a word of width w (w in 2..32).
    function automatic logic [31:0] most_neg(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/num_fmt_conv_core.sv
// Combinational conversion between two's complement and sign-magnitude.
// Produces the converted word plus the saturation and negative-zero flags.
module num_fmt_conv_core
    import num_fmt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf,
    output logic             o_negz
);

    localparam logic [WIDTH-1:0] MNEG = WIDTH'(most_neg(WIDTH));

    logic             w_sign;
    logic [WIDTH-2:0] w_mag;
    logic [WIDTH-1:0] w_neg;

    assign w_sign = i_data[WIDTH-1];
    assign w_mag  = i_data[WIDTH-2:0];
    assign w_neg  = ~i_data + WIDTH'(1);

    // Positive words pass through in both directions; only negatives are rewritten.
    always_comb begin
        o_result = i_data;
        o_ovf    = 1'b0;
        o_negz   = 1'b0;
        if (w_sign) begin
            if (i_mode == MODE_TC2SM) begin
                if (i_data == MNEG) begin
                    // -2^(W-1) has no sign-magnitude form: clamp to largest negative magnitude.
                    o_result = {1'b1, {(WIDTH-1){1'b1}}};
                    o_ovf    = 1'b1;
                end else begin
                    o_result = {1'b1, w_neg[WIDTH-2:0]};
                end
            end else begin
                if (w_mag == '0) begin
                    o_result = '0;
                    o_negz   = 1'b1;
                end else begin
                    o_result = ~{1'b0, w_mag} + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/num_fmt_conv.sv
// Two-stage streaming number-format converter with valid/ready on both sides.
// Define NUM_FMT_CONV_STATS_EN to build the saturating overflow-event counter;
// without it ovf_cnt reads 0 and clr_cnt is ignored.
module num_fmt_conv
    import num_fmt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_negz,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             clr_cnt
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s1_mode;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_ovf;
    logic             r_out_negz;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic             w_negz;

    // A stage may load when it is empty or the stage after it is moving.
    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign out_negz  = r_out_negz;

    num_fmt_conv_core #(.WIDTH(WIDTH)) u_core (
        .i_data   (r_s1_data),
        .i_mode   (r_s1_mode),
        .o_result (w_result),
        .o_ovf    (w_ovf),
        .o_negz   (w_negz)
    );

    // Stage 1: capture the raw word and direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= MODE_TC2SM;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_mode <= in_mode;
            end
        end
    end

    // Stage 2: capture the converted word; holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
            r_out_negz <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_result;
                r_out_ovf  <= w_ovf;
                r_out_negz <= w_negz;
            end
        end
    end

`ifdef NUM_FMT_CONV_STATS_EN
    logic [CNT_W-1:0] r_ovf_cnt;

    // Count delivered saturated words; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (clr_cnt) begin
            r_ovf_cnt <= '0;
        end else if (r_s2_valid && out_ready && r_out_ovf && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_cnt;
    assign ovf_cnt      = '0;
`endif

endmodule
